// File: rtl/router_pkg.sv
// Shared types and constants for the router ingress stage.
package router_pkg;

  localparam int unsigned ADDR_W       = 2;
  localparam int unsigned NUM_PORTS    = 4;
  localparam int unsigned HDR_ADDR_LSB = 0;
  localparam int unsigned DEF_DATA_W   = 32;

  typedef enum logic {
    S_HDR = 1'b0,
    S_PAY = 1'b1
  } state_e;

  // Default-width FIFO entry; the top redeclares it at its own DATA_WIDTH.
  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [DEF_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/router_ingress_fifo.sv
// Generic synchronous FIFO: wrap-around pointers plus occupancy counter, no bypass.
module router_ingress_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/router_ingress.sv
// Router ingress: strips packet headers, tags payload with destination, buffers
// and issues one word per cycle to the router unless stalled.
module router_ingress
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  input  logic                         stall,
  output logic [DATA_WIDTH-1:0]        din,
  output logic                         din_en,
  output logic [ADDR_W-1:0]            addr,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         hdr_err
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_WIDTH;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              hdr_err_q, hdr_err_d;
  logic              full, empty, xfer, push, pop;
  entry_t            wr_entry, rd_entry;

  assign in_ready = (state_q == S_HDR) || !full;
  assign xfer     = in_valid && in_ready;
  assign push     = xfer && (state_q == S_PAY);
  assign pop      = !empty && !stall;

  assign wr_entry.addr = cur_addr_q;
  assign wr_entry.data = in_data;

  router_ingress_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (wr_entry),
    .rdata  (rd_entry),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

  // Header/payload framing; a header with in_last is an empty packet.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    hdr_err_d  = 1'b0;
    case (state_q)
      S_HDR: begin
        if (xfer) begin
          cur_addr_d = in_data[HDR_ADDR_LSB +: ADDR_W];
          if (in_last) hdr_err_d = 1'b1;
          else         state_d   = S_PAY;
        end
      end
      S_PAY: begin
        if (xfer && in_last) state_d = S_HDR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_HDR;
      cur_addr_q <= '0;
      hdr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      hdr_err_q  <= hdr_err_d;
    end
  end

  // Router interface is zero whenever no word is issued.
  assign din_en  = pop;
  assign din     = pop ? rd_entry.data : '0;
  assign addr    = pop ? rd_entry.addr : '0;
  assign hdr_err = hdr_err_q;

endmodule

// File: doc/router_ingress.md
Name: router_ingress

Overview:
- Ingress stage directly upstream of the 4-way simple router.
- Accepts a framed valid/ready packet stream, strips the one-word header and latches its 2-bit destination.
- Buffers payload words, each tagged with its destination, in a small FIFO.
- Presents one word per cycle on the router's din/din_en/addr inputs. The router has no backpressure, so flow control ends here, apart from a downstream stall input.

Parameters:
- DATA_WIDTH, 32, width of stream words and of din.
- FIFO_DEPTH, 4, payload FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- in_data  input  DATA_WIDTH  stream word; header or payload.
- in_valid  input  1  in_data valid.
- in_last  input  1  marks the final word of a packet.
- in_ready  output  1  block can accept in_data this cycle.
- stall  input  1  downstream hold; while high no word is issued.
- din  output  DATA_WIDTH  word to the router.
- din_en  output  1  din/addr valid this cycle.
- addr  output  2  destination port for din.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- hdr_err  output  1  one-cycle pulse on a header carrying in_last (empty packet).

Behaviour:
- Clock, reset and handshake
  - One clock domain.
  - Reset is asynchronous and active-low on resetn. It clears the FSM to S_HDR, the FIFO pointers and count, the latched destination and hdr_err.
  - A transfer occurs when in_valid && in_ready at a rising edge.
  - Reset mid-packet discards the partial packet and all buffered words; the next accepted word is treated as a header.
- Reset values of outputs
  - din, din_en, addr, fifo_count and hdr_err are 0.
  - in_ready is 1 after reset (S_HDR).
- FSM states: S_HDR, S_PAY.
  - S_HDR
    - in_ready = 1; the header never enters the FIFO.
    - On transfer, cur_addr <= in_data[1:0].
    - If in_last = 0, go to S_PAY.
    - If in_last = 1, stay in S_HDR, pulse hdr_err for one cycle, and forward nothing.
  - S_PAY
    - in_ready = !full.
    - On transfer, push {cur_addr, in_data}.
    - If in_last = 1, return to S_HDR. The next packet's header can be taken the following cycle.
- FIFO
  - Synchronous, with wrap-around read/write pointers plus an occupancy counter.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
  - Push and pop in the same cycle leave count unchanged.
  - There is no write-through bypass: when full, in_ready = 0 even if a pop occurs that cycle.
- Output (combinational from the FIFO head)
  - din_en = !empty && !stall.
  - When din_en = 1, din and addr carry the head entry and the head pops at the clock edge.
  - When din_en = 0, din = 0 and addr = 0. This matches the router, which zeroes its outputs without an enable.
- Latency and ordering
  - A payload word accepted at edge N appears with din_en = 1 in the cycle after edge N, if stall is low and no older words remain.
  - Sustained throughput is 1 word/cycle.
  - Order is strictly preserved.
  - Each word carries its own packet's addr, so packets to different ports may be back-to-back in the FIFO.
- Stall
  - Affects only the output side.
  - The FIFO keeps filling until full, then in_ready falls in S_PAY.
  - Deasserting stall resumes issue from the head in that same cycle.

Decomposition:
- Package router_pkg holds:
  - ADDR_W = 2 and NUM_PORTS = 4.
  - HDR_ADDR_LSB = 0, the header field position.
  - The state enum typedef {S_HDR, S_PAY}.
  - A FIFO entry struct typedef {addr, data} parameterised by DATA_WIDTH through a localparam at use.
- One sub-module, router_ingress_fifo: generic sync FIFO with push, pop, full, empty and count, asynchronous active-low reset.
- The top level holds the FSM and the output gating.

Test Plan:
- Reset then idle: resetn low with in_valid = 1 -> din_en = 0, din = 0, addr = 0, in_ready = 1, fifo_count = 0; after release, no output until a header plus payload arrive.
- Single packet, no stall: header 0x0000_0002, then payloads 0xA, 0xB (0xB with in_last) -> the cycle after each payload's edge: din_en = 1, addr = 2, din = 0xA, then 0xB; fifo_count returns to 0.
- Back-to-back packets:
  - Stimulus: hdr 0x1 + payload 0x11 (last), then hdr 0x3 + payload 0x33 (last).
  - Response: output addr = 1/din = 0x11, then addr = 3/din = 0x33, with no word lost or reordered.
- Full FIFO with stall:
  - Stimulus: stall = 1; hdr 0x0, then 6 payloads 0x1..0x6.
  - Response: fifo_count reaches 4 and in_ready = 0 while 0x5 is held; on stall = 0, words 0x1..0x6 emerge in order on consecutive cycles with addr = 0.
- Empty packet: header 0x2 with in_last = 1 -> hdr_err pulses once, no din_en, FSM stays in S_HDR; the next header is accepted normally.
- Reset mid-packet: hdr 0x1 + 2 payloads with stall = 1, then assert resetn low -> fifo_count = 0, din_en = 0; post-reset, the first word is treated as a header.
